mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: memory access latency in cycles; legal range 1..7.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while fetch waits (MEM_ARB_FAIR_EN only).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  arbitration enable; while low, no new grants.
REQ-006 SHALL have ports if_req_i in 1, if_addr_i in 32: fetch read request and address.
REQ-007 SHALL have ports if_rdata_o out 32, if_ready_o out 1: fetch read data and one-cycle completion pulse.
REQ-008 SHALL have ports dm_req_i in 1, dm_we_i in 1, dm_addr_i in 32, dm_wdata_i in 32: data request, write enable, address and write data.
REQ-009 SHALL have ports dm_rdata_o out 32, dm_ready_o out 1: data read data and one-cycle completion pulse.
REQ-010 SHALL have ports mem_en_o out 1, mem_we_o out 1, mem_addr_o out 32, mem_wdata_o out 32, mem_rdata_i in 32: shared single-port memory.
REQ-011 SHALL have port stall_o  output  1  pipeline freeze request.

Function
REQ-012 SHALL implement states IDLE, BUSY, RESP.
REQ-013 SHALL, in IDLE with start_i=1 and any request, grant, latch addr/we/wdata of the grantee, load cycle counter with MEM_LAT-1, and go to BUSY.
REQ-014 SHALL grant dm over if when both request in the same IDLE cycle (strict priority, unless REQ-026 applies).
REQ-015 SHALL drive mem_en_o=1 and mem_addr_o/mem_we_o/mem_wdata_o from latched values throughout BUSY; mem_en_o=0 and mem_we_o=0 otherwise.
REQ-016 SHALL decrement the counter each BUSY cycle; at counter 0, capture mem_rdata_i into the grantee's rdata register (reads only) and go to RESP.
REQ-017 SHALL assert exactly the grantee's ready output for the single RESP cycle, then return to IDLE.
REQ-018 SHALL give latency: request sampled at edge k -> BUSY cycles k+1..k+MEM_LAT -> ready high in cycle k+MEM_LAT+1.
REQ-019 SHALL hold if_rdata_o/dm_rdata_o at last captured value; writes leave dm_rdata_o unchanged.
REQ-020 SHALL ignore requests during BUSY and RESP; requester holds req until ready and drops it the following cycle, or it is a new request.
REQ-021 SHALL complete an access whose requester drops req mid-BUSY, still pulsing ready.
REQ-022 SHALL complete an in-flight access if start_i falls during BUSY.
REQ-023 SHALL drive stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o), combinationally.

Reset
REQ-024 SHALL, on rst_i=1 at a clock edge (including mid-BUSY), enter IDLE, clear counter, latched request and starvation counter; the access is abandoned.
REQ-025 SHALL reset outputs: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if_ready_o=0, dm_ready_o=0, if_rdata_o=0, dm_rdata_o=0.

Configuration
REQ-026 SHALL, with MEM_ARB_FAIR_EN defined, count consecutive dm grants made while if_req_i=1; when count equals STARVE_MAX, the next IDLE grant goes to if even if dm requests; count clears on any if grant or when if_req_i=0 at a grant.
REQ-027 SHALL, without MEM_ARB_FAIR_EN, contain no starvation counter and use strict dm priority.

Verification
REQ-028 SHALL cover: MEM_LAT=2, if_req_i=1, if_addr_i=0x10, mem_rdata_i=0x8C010004 -> mem_en_o high 2 cycles at 0x10, if_ready_o pulse 3 cycles after request edge, if_rdata_o=0x8C010004.
REQ-029 SHALL cover: if and dm request same cycle, dm_we_i=1, dm_addr_i=0x20, dm_wdata_i=0x5 -> mem_we_o=1 addr 0x20 data 0x5 first, dm_ready_o pulse, then fetch served; stall_o high until if_ready_o.
REQ-030 SHALL cover: rst_i=1 in second BUSY cycle -> next cycle mem_en_o=0, no ready pulse, all outputs 0.
REQ-031 SHALL cover: start_i=0 with if_req_i=1 -> mem_en_o stays 0, stall_o=1; start_i=1 -> grant next edge.
REQ-032 SHALL cover: MEM_ARB_FAIR_EN, STARVE_MAX=4, both requests held continuously -> grant sequence dm,dm,dm,dm,if,dm...; without macro -> dm only.
REQ-033 SHALL cover: MEM_LAT=1, back-to-back dm reads 0x0,0x4 -> each ready 2 cycles after its request edge, one IDLE cycle between accesses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory; optional fetch fairness via `MEM_ARB_FAIR_EN.
// Latency: grant edge + MEM_LAT busy cycles, ready pulse in the following cycle; requests are ignored while busy.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_chk
        $error("mem_arbiter: MEM_LAT must be in 1..7");
    end
    if (STARVE_MAX < 1) begin : g_starve_chk
        $error("mem_arbiter: STARVE_MAX must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_gnt_dm;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        w_grant;
    logic        w_done;
    logic        w_sel_dm;
    logic        w_force_if;

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] r_starve;

    // Once data has won STARVE_MAX times in a row over a waiting fetch, fetch wins next.
    assign w_force_if = if_req_i & (r_starve == STARVE_W'(STARVE_MAX));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_sel_dm && if_req_i) begin
                r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_sel_dm    = dm_req_i & ~w_force_if;
        case (r_state)
            IDLE: begin
                if (start_i && (if_req_i || dm_req_i)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 3'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_gnt_dm   <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gnt_dm <= w_sel_dm;
                r_we     <= w_sel_dm & dm_we_i;
                r_addr   <= w_sel_dm ? dm_addr_i : if_addr_i;
                r_wdata  <= w_sel_dm ? dm_wdata_i : 32'd0;
                r_cnt    <= 3'(MEM_LAT - 1);
            end else if (r_state == BUSY && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            // Read data lands on the final busy edge; writes leave both rdata registers alone.
            if (w_done && !r_we) begin
                if (r_gnt_dm) begin
                    r_dm_rdata <= mem_rdata_i;
                end else begin
                    r_if_rdata <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_en_o    = (r_state == BUSY);
    assign mem_we_o    = (r_state == BUSY) & r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign if_ready_o  = (r_state == RESP) & ~r_gnt_dm;
    assign dm_ready_o  = (r_state == RESP) & r_gnt_dm;
    assign if_rdata_o  = r_if_rdata;
    assign dm_rdata_o  = r_dm_rdata;
    assign stall_o     = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

endmodule
